// File: rtl/vid_pkg.sv
// Shared types, timing constants and saturating helpers for the video capture path.
package vid_pkg;

  localparam int PIX_W   = 24;
  localparam int COORD_W = 11;
  localparam int MEAS_W  = 12;

  // 1280x960 reference timing: sync end / active start / active end / total
  localparam int H_SYNC_END  = 112;
  localparam int H_ACT_START = 424;
  localparam int H_ACT_END   = 1704;
  localparam int H_TOTAL     = 1800;
  localparam int V_SYNC_END  = 3;
  localparam int V_ACT_START = 39;
  localparam int V_ACT_END   = 999;
  localparam int V_TOTAL     = 1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DONE
  } state_t;

  function automatic logic [COORD_W-1:0] satIncCoord(input logic [COORD_W-1:0] v);
    return (v == {COORD_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [MEAS_W-1:0] satIncMeas(input logic [MEAS_W-1:0] v);
    return (v == {MEAS_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vid_edge_det.sv
// Two-stage registered level/edge detector; POL=0 inverts the input so the
// outputs always describe the active level.
module vid_edge_det
  import vid_pkg::*;
#(
  parameter bit POL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= POL ? i_d : ~i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_level = r_s1;
  assign o_rise  = r_s1 & ~r_s2;
  assign o_fall  = ~r_s1 & r_s2;

endmodule

// File: rtl/vid_capture.sv
// Video input capture: locks to vsync, gates de/RGB into a pixel-write stream
// with coordinates and error pulses. Optional macro VID_CAPTURE_MEASURE_EN adds h_total/v_total.
module vid_capture
  import vid_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 960,
  parameter int SYNC_POL = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cap_en,
  input  logic               vsync_in,
  input  logic               hsync_in,
  input  logic               de_in,
  input  logic [PIX_W-1:0]   rgb_in,
  input  logic               fifo_full,
  output logic               pix_wr_en,
  output logic [PIX_W-1:0]   pix_data,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               frame_start,
  output logic               frame_done,
  output logic               line_err,
  output logic               frame_err,
  output logic               ovf_err
`ifdef VID_CAPTURE_MEASURE_EN
  ,
  output logic [MEAS_W-1:0]  h_total,
  output logic [MEAS_W-1:0]  v_total
`endif
);

  localparam logic [COORD_W-1:0] H_LIM = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_LIM = COORD_W'(V_ACTIVE);

  logic w_vsLevel, w_vsRise, w_vsFall;
  logic w_deLevel, w_deRise, w_deFall;
  logic w_unused;
  logic w_unusedHs;

  logic [PIX_W-1:0] r_rgb;

  state_t           r_state, w_stateNxt;
  logic [COORD_W-1:0] r_xCnt, w_xCntNxt;
  logic [COORD_W-1:0] r_yCnt, w_yCntNxt;
  logic               r_skip, w_skipNxt;
  logic [COORD_W-1:0] w_xInc, w_yInc;

  logic               r_wrEn, w_wrEnNxt;
  logic [PIX_W-1:0]   r_data, w_dataNxt;
  logic [COORD_W-1:0] r_pixX, w_pixXNxt;
  logic [COORD_W-1:0] r_pixY, w_pixYNxt;
  logic               r_fStart, w_fStartNxt;
  logic               r_fDone, w_fDoneNxt;
  logic               r_lineErr, w_lineErrNxt;
  logic               r_frameErr, w_frameErrNxt;
  logic               r_ovf, w_ovfNxt;

  vid_edge_det #(.POL(SYNC_POL != 0)) u_vsync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_d     (vsync_in),
    .o_level (w_vsLevel),
    .o_rise  (w_vsRise),
    .o_fall  (w_vsFall)
  );

  vid_edge_det #(.POL(1'b1)) u_de (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_d     (de_in),
    .o_level (w_deLevel),
    .o_rise  (w_deRise),
    .o_fall  (w_deFall)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= rgb_in;
    end
  end

  assign w_xInc = satIncCoord(r_xCnt);
  assign w_yInc = satIncCoord(r_yCnt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_xCnt     <= '0;
      r_yCnt     <= '0;
      r_skip     <= 1'b0;
      r_wrEn     <= 1'b0;
      r_data     <= '0;
      r_pixX     <= '0;
      r_pixY     <= '0;
      r_fStart   <= 1'b0;
      r_fDone    <= 1'b0;
      r_lineErr  <= 1'b0;
      r_frameErr <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_stateNxt;
      r_xCnt     <= w_xCntNxt;
      r_yCnt     <= w_yCntNxt;
      r_skip     <= w_skipNxt;
      r_wrEn     <= w_wrEnNxt;
      r_data     <= w_dataNxt;
      r_pixX     <= w_pixXNxt;
      r_pixY     <= w_pixYNxt;
      r_fStart   <= w_fStartNxt;
      r_fDone    <= w_fDoneNxt;
      r_lineErr  <= w_lineErrNxt;
      r_frameErr <= w_frameErrNxt;
      r_ovf      <= w_ovfNxt;
    end
  end

  // A vsync edge overrides everything else; a line already in progress at
  // that moment is skipped until its de falls, without counting it.
  always_comb begin
    w_stateNxt    = r_state;
    w_xCntNxt     = r_xCnt;
    w_yCntNxt     = r_yCnt;
    w_skipNxt     = r_skip;
    w_wrEnNxt     = 1'b0;
    w_dataNxt     = r_data;
    w_pixXNxt     = r_pixX;
    w_pixYNxt     = r_pixY;
    w_fStartNxt   = 1'b0;
    w_fDoneNxt    = 1'b0;
    w_lineErrNxt  = 1'b0;
    w_frameErrNxt = 1'b0;
    w_ovfNxt      = r_ovf;

    if (w_vsRise) begin
      w_frameErrNxt = (r_state == ST_ACTIVE) && (r_yCnt < V_LIM);
      w_xCntNxt     = '0;
      w_yCntNxt     = '0;
      if (cap_en) begin
        w_stateNxt  = ST_ACTIVE;
        w_fStartNxt = 1'b1;
        w_pixYNxt   = '0;
        w_ovfNxt    = 1'b0;
        w_skipNxt   = w_deLevel;
      end else begin
        w_stateNxt  = ST_IDLE;
        w_skipNxt   = 1'b0;
      end
    end else if (r_state == ST_ACTIVE) begin
      if (w_deFall) begin
        w_xCntNxt = '0;
        if (r_skip) begin
          w_skipNxt = 1'b0;
        end else begin
          w_lineErrNxt = (r_xCnt != H_LIM);
          w_yCntNxt    = w_yInc;
          if (w_yInc == V_LIM) begin
            w_fDoneNxt = 1'b1;
            w_stateNxt = ST_DONE;
          end
        end
      end else if (w_deLevel && !r_skip) begin
        // x keeps counting past the active width so over-long lines are caught
        if (r_xCnt < H_LIM) begin
          w_wrEnNxt = ~fifo_full;
          w_dataNxt = r_rgb;
          w_pixXNxt = r_xCnt;
          w_pixYNxt = r_yCnt;
          if (fifo_full) begin
            w_ovfNxt = 1'b1;
          end
        end
        w_xCntNxt = w_xInc;
      end
    end
  end

  assign pix_wr_en   = r_wrEn;
  assign pix_data    = r_data;
  assign pix_x       = r_pixX;
  assign pix_y       = r_pixY;
  assign frame_start = r_fStart;
  assign frame_done  = r_fDone;
  assign line_err    = r_lineErr;
  assign frame_err   = r_frameErr;
  assign ovf_err     = r_ovf;

`ifdef VID_CAPTURE_MEASURE_EN
  logic              w_hsLevel, w_hsRise, w_hsFall;
  logic [MEAS_W-1:0] r_hCnt, r_vCnt, r_hTotal, r_vTotal;

  vid_edge_det #(.POL(SYNC_POL != 0)) u_hsync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_d     (hsync_in),
    .o_level (w_hsLevel),
    .o_rise  (w_hsRise),
    .o_fall  (w_hsFall)
  );

  // An hsync edge coincident with vsync belongs to the new frame's count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hCnt   <= '0;
      r_vCnt   <= '0;
      r_hTotal <= '0;
      r_vTotal <= '0;
    end else begin
      if (w_hsRise) begin
        r_hTotal <= r_hCnt;
        r_hCnt   <= MEAS_W'(1);
      end else begin
        r_hCnt <= satIncMeas(r_hCnt);
      end
      if (w_vsRise) begin
        r_vTotal <= r_vCnt;
        r_vCnt   <= w_hsRise ? MEAS_W'(1) : '0;
      end else if (w_hsRise) begin
        r_vCnt <= satIncMeas(r_vCnt);
      end
    end
  end

  assign h_total    = r_hTotal;
  assign v_total    = r_vTotal;
  assign w_unusedHs = w_hsLevel ^ w_hsFall;
`else
  assign w_unusedHs = hsync_in;
`endif

  assign w_unused = ^{w_vsLevel, w_vsFall, w_deRise, w_unusedHs};

endmodule

// File: tb/tb_vid_capture.sv
// Directed self-checking bench for vid_capture at H_ACTIVE=8, V_ACTIVE=4.
module tb_vid_capture;

  logic        clk;
  logic        rst_n;
  logic        cap_en;
  logic        vsync_in;
  logic        hsync_in;
  logic        de_in;
  logic [23:0] rgb_in;
  logic        fifo_full;
  logic        pix_wr_en;
  logic [23:0] pix_data;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic        frame_start;
  logic        frame_done;
  logic        line_err;
  logic        frame_err;
  logic        ovf_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [23:0] wrData[$];
  int          wrX[$];
  int          wrY[$];
  int          wrCyc[$];
  int fsCount = 0;
  int fdCount = 0;
  int leCount = 0;
  int feCount = 0;
  int fsFeCount = 0;

  vid_capture #(.H_ACTIVE(8), .V_ACTIVE(4), .SYNC_POL(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cap_en      (cap_en),
    .vsync_in    (vsync_in),
    .hsync_in    (hsync_in),
    .de_in       (de_in),
    .rgb_in      (rgb_in),
    .fifo_full   (fifo_full),
    .pix_wr_en   (pix_wr_en),
    .pix_data    (pix_data),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .line_err    (line_err),
    .frame_err   (frame_err),
    .ovf_err     (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled mid-cycle; the directed steps compare against its deltas.
  always @(negedge clk) begin
    if (pix_wr_en) begin
      wrData.push_back(pix_data);
      wrX.push_back(int'(pix_x));
      wrY.push_back(int'(pix_y));
      wrCyc.push_back(cyc);
    end
    fsCount   += int'(frame_start);
    fdCount   += int'(frame_done);
    leCount   += int'(line_err);
    feCount   += int'(frame_err);
    fsFeCount += int'(frame_start & frame_err);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic vs, input logic de, input logic [23:0] rgb, input logic full);
    vsync_in  = vs;
    de_in     = de;
    rgb_in    = rgb;
    fifo_full = full;
    @(posedge clk);
    #1;
  endtask

  task automatic sendVsync();
    applyStimulus(1'b1, 1'b0, 24'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 24'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 24'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 24'd0, 1'b0);
  endtask

  // fifo_full is consumed unregistered, one cycle after the pixel is driven
  task automatic sendLine(input int n, input int base, input int fullLo, input int fullHi,
                          output int firstCyc);
    firstCyc = cyc;
    for (int i = 0; i <= n; i++) begin
      applyStimulus(1'b0, (i < n), 24'(base + i),
                    ((i - 1) >= fullLo) && ((i - 1) <= fullHi));
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 24'd0, 1'b0);
  endtask

  int wb, fsb, fdb, leb, feb, sfb, inCyc, dummy;

  initial begin
    rst_n = 1'b0; cap_en = 1'b1; hsync_in = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 24'd0, 1'b0);
    checkOutput("rst_wr_en",   pix_wr_en,   0);
    checkOutput("rst_data",    pix_data,    0);
    checkOutput("rst_fstart",  frame_start, 0);
    checkOutput("rst_ovf",     ovf_err,     0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 24'd0, 1'b0);

    // clean frame
    wb = wrData.size(); fsb = fsCount; fdb = fdCount; leb = leCount; feb = feCount;
    sendVsync();
    sendLine(8, 0, -1, -1, inCyc);
    sendLine(8, 8, -1, -1, dummy);
    sendLine(8, 16, -1, -1, dummy);
    sendLine(8, 24, -1, -1, dummy);
    checkOutput("clean_writes",  wrData.size() - wb, 32);
    checkOutput("clean_first_d", wrData[wb], 0);
    checkOutput("clean_first_x", wrX[wb], 0);
    checkOutput("clean_first_y", wrY[wb], 0);
    checkOutput("clean_latency", wrCyc[wb] - inCyc, 2);
    checkOutput("clean_mid_d",   wrData[wb+21], 21);
    checkOutput("clean_mid_xy",  wrX[wb+21] * 16 + wrY[wb+21], 5 * 16 + 2);
    checkOutput("clean_last_d",  wrData[wb+31], 31);
    checkOutput("clean_last_x",  wrX[wb+31], 7);
    checkOutput("clean_last_y",  wrY[wb+31], 3);
    checkOutput("clean_fstart",  fsCount - fsb, 1);
    checkOutput("clean_fdone",   fdCount - fdb, 1);
    checkOutput("clean_lineerr", leCount - leb, 0);
    checkOutput("clean_frmerr",  feCount - feb, 0);
    checkOutput("clean_ovf",     ovf_err, 0);

    // line 1 has nine de clocks
    wb = wrData.size(); fdb = fdCount; leb = leCount;
    sendVsync();
    sendLine(8, 0, -1, -1, dummy);
    sendLine(9, 8, -1, -1, dummy);
    sendLine(8, 16, -1, -1, dummy);
    sendLine(8, 24, -1, -1, dummy);
    checkOutput("long_writes",  wrData.size() - wb, 32);
    checkOutput("long_lineerr", leCount - leb, 1);
    checkOutput("long_l2_d",    wrData[wb+16], 16);
    checkOutput("long_l2_xy",   wrX[wb+16] * 16 + wrY[wb+16], 0 * 16 + 2);
    checkOutput("long_fdone",   fdCount - fdb, 1);

    // early vsync after two lines
    wb = wrData.size(); fsb = fsCount; fdb = fdCount; feb = feCount; sfb = fsFeCount;
    sendVsync();
    sendLine(8, 0, -1, -1, dummy);
    sendLine(8, 8, -1, -1, dummy);
    sendVsync();
    for (int l = 0; l < 4; l++) sendLine(8, 100 + 8 * l, -1, -1, dummy);
    checkOutput("early_writes",  wrData.size() - wb, 48);
    checkOutput("early_frmerr",  feCount - feb, 1);
    checkOutput("early_samecyc", fsFeCount - sfb, 1);
    checkOutput("early_fstart",  fsCount - fsb, 2);
    checkOutput("early_restart_y", wrY[wb+16], 0);
    checkOutput("early_restart_d", wrData[wb+16], 100);
    checkOutput("early_fdone",   fdCount - fdb, 1);

    // capture disabled for one frame
    wb = wrData.size(); fsb = fsCount;
    cap_en = 1'b0;
    sendVsync();
    cap_en = 1'b1;
    for (int l = 0; l < 4; l++) sendLine(8, 8 * l, -1, -1, dummy);
    checkOutput("capoff_writes", wrData.size() - wb, 0);
    checkOutput("capoff_fstart", fsCount - fsb, 0);
    wb = wrData.size(); fdb = fdCount;
    sendVsync();
    for (int l = 0; l < 4; l++) sendLine(8, 8 * l, -1, -1, dummy);
    checkOutput("capon_writes",  wrData.size() - wb, 32);
    checkOutput("capon_fstart",  fsCount - fsb, 1);
    checkOutput("capon_fdone",   fdCount - fdb, 1);

    // fifo_full across pixels 3..5 of line 0
    wb = wrData.size();
    sendVsync();
    sendLine(8, 0, 3, 5, dummy);
    checkOutput("ovf_set_midframe", ovf_err, 1);
    for (int l = 1; l < 4; l++) sendLine(8, 8 * l, -1, -1, dummy);
    checkOutput("ovf_writes",   wrData.size() - wb, 29);
    checkOutput("ovf_before_d", wrData[wb+2], 2);
    checkOutput("ovf_after_d",  wrData[wb+3], 6);
    checkOutput("ovf_after_x",  wrX[wb+3], 6);
    checkOutput("ovf_sticky",   ovf_err, 1);

    // reset pulse during line 2
    sendVsync();
    checkOutput("ovf_cleared", ovf_err, 0);
    sendLine(8, 0, -1, -1, dummy);
    sendLine(8, 8, -1, -1, dummy);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 24'(16 + i), 1'b0);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b1, 24'd19, 1'b0);
    checkOutput("rstmid_wr_en", pix_wr_en, 0);
    checkOutput("rstmid_data",  pix_data,  0);
    checkOutput("rstmid_x",     pix_x,     0);
    checkOutput("rstmid_y",     pix_y,     0);
    rst_n = 1'b1;
    wb = wrData.size(); fsb = fsCount;
    for (int i = 4; i < 8; i++) applyStimulus(1'b0, 1'b1, 24'(16 + i), 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 24'd0, 1'b0);
    sendLine(8, 24, -1, -1, dummy);
    checkOutput("rstmid_no_writes", wrData.size() - wb, 0);
    sendVsync();
    for (int l = 0; l < 4; l++) sendLine(8, 8 * l, -1, -1, dummy);
    checkOutput("rstmid_resume_writes", wrData.size() - wb, 32);
    checkOutput("rstmid_resume_fstart", fsCount - fsb, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
